// File: rtl/jtag_cmd_sequencer_if.sv
// Register-bus request/acknowledge bundle between the JTAG command sequencer and the fabric register file.
// The master holds req with wr/addr/wdata until a single-cycle ack (with rdata on reads) or its own timeout.
interface jtag_cmd_sequencer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) ();
  logic                  bus_req;
  logic                  bus_wr;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_ack;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/jtag_cmd_sequencer.sv
// Turns each JTAG Update-DR toggle into one register-bus read/write; bus_req rises 3 clocks after the toggle lands in s1.
// The bus stalls via a withheld ack up to TIMEOUT_CYCLES; a JTAG command arriving while busy is dropped and flagged as overrun.
module jtag_cmd_sequencer #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           jtag_update_toggle_i,
  input  logic [ADDR_WIDTH+DATA_WIDTH:0] jtag_control_i,
  jtag_cmd_sequencer_if.master           bus,
  output logic [DATA_WIDTH+3:0]          status_o
);

  localparam int              CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam int              MSB      = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_REQ, S_DONE} state_e;

  state_e                state_q, state_d;
  logic                  s1_q, s2_q, s3_q;
  logic [1:0]            prime_q;
  logic                  evt;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cmd_rnw_q, cmd_rnw_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_wr_q, bus_wr_d;
  logic                  busy_q, busy_d;
  logic                  timeout_q, timeout_d;
  logic                  overrun_q, overrun_d;
  logic                  last_rnw_q, last_rnw_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Prime counter masks the edge seen when the toggle is already 1 at reset release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      prime_q <= 2'd0;
    end else begin
      s1_q <= jtag_update_toggle_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
    end
  end

  assign evt = (s2_q ^ s3_q) && (prime_q == 2'd3);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_rnw_d   = cmd_rnw_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    bus_wr_d    = bus_wr_q;
    timeout_d   = timeout_q;
    rdata_d     = rdata_q;
    last_rnw_d  = last_rnw_q;
    overrun_d   = overrun_q | (evt && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (evt) state_d = S_LATCH;
      end
      S_LATCH: begin
        cmd_rnw_d   = jtag_control_i[MSB];
        cmd_addr_d  = jtag_control_i[DATA_WIDTH +: ADDR_WIDTH];
        cmd_wdata_d = jtag_control_i[DATA_WIDTH-1:0];
        bus_wr_d    = ~jtag_control_i[MSB];
        timeout_d   = 1'b0;
        cnt_d       = '0;
        state_d     = S_REQ;
      end
      S_REQ: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (bus.bus_ack) begin
          if (cmd_rnw_q) rdata_d = bus.bus_rdata;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        last_rnw_d = cmd_rnw_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    bus_req_d = (state_d == S_REQ);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_rnw_q   <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      bus_req_q   <= 1'b0;
      bus_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      last_rnw_q  <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_rnw_q   <= cmd_rnw_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      bus_req_q   <= bus_req_d;
      bus_wr_q    <= bus_wr_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
      last_rnw_q  <= last_rnw_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_wr    = bus_wr_q;
  assign bus.bus_addr  = cmd_addr_q;
  assign bus.bus_wdata = cmd_wdata_q;
  assign status_o      = {busy_q, timeout_q, overrun_q, last_rnw_q, rdata_q};

endmodule

// File: tb/tb_jtag_cmd_sequencer.sv
// Bench for jtag_cmd_sequencer: directed and random JTAG commands with a transaction-level model of request length and status.
module tb_jtag_cmd_sequencer;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        tog;
  logic [12:0] ctrl;
  logic [11:0] status;

  int n_cmp = 0;
  int n_bad = 0;

  logic       exp_timeout, exp_overrun, exp_last_rnw;
  logic [7:0] exp_rdata;

  jtag_cmd_sequencer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus_if ();

  jtag_cmd_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .jtag_update_toggle_i(tog),
    .jtag_control_i      (ctrl),
    .bus                 (bus_if),
    .status_o            (status)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] exp_status(input logic busy);
    return {busy, exp_timeout, exp_overrun, exp_last_rnw, exp_rdata};
  endfunction

  // One JTAG command: ack_at = REQ cycle carrying the ack (0 = never); dup re-toggles during REQ.
  task automatic run_cmd(input bit rnw, input logic [3:0] addr, input logic [7:0] wd,
                         input logic [7:0] rd, input int ack_at, input bit dup, input string nm);
    int  lat;
    int  len;
    int  exp_len;
    bit  acked;
    @(negedge clk);
    ctrl = {rnw, addr, wd};
    repeat (5) @(negedge clk);
    tog = ~tog;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus_if.bus_req && lat < 12);
    n_cmp++;
    if (lat != 4) begin
      n_bad++;
      $display("FAIL %s latency: bus_req seen after %0d cycles, want 4", nm, lat);
    end
    len = 0;
    while (bus_if.bus_req && len < TO + 8) begin
      len++;
      n_cmp++;
      if ({bus_if.bus_wr, bus_if.bus_addr, bus_if.bus_wdata} !== {~rnw, addr, wd}) begin
        n_bad++;
        $display("FAIL %s bus_fields cyc %0d: got wr=%b addr=%h wdata=%h, want wr=%b addr=%h wdata=%h",
                 nm, len, bus_if.bus_wr, bus_if.bus_addr, bus_if.bus_wdata, ~rnw, addr, wd);
      end
      if (dup && len == 2) tog = ~tog;
      if (len == ack_at) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = rd;
      end else begin
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 8'($urandom);
      end
      @(negedge clk);
    end
    bus_if.bus_ack = 1'b0;
    acked   = (ack_at >= 1 && ack_at <= TO);
    exp_len = acked ? ack_at : TO;
    n_cmp++;
    if (len != exp_len) begin
      n_bad++;
      $display("FAIL %s req_len: got %0d cycles, want %0d", nm, len, exp_len);
    end
    exp_timeout = !acked;
    if (acked && rnw) exp_rdata = rd;
    if (dup) exp_overrun = 1'b1;
    n_cmp++;
    if (status !== exp_status(1'b1)) begin
      n_bad++;
      $display("FAIL %s status_done: got %h, want %h", nm, status, exp_status(1'b1));
    end
    @(negedge clk);
    exp_last_rnw = rnw;
    n_cmp++;
    if (status !== exp_status(1'b0)) begin
      n_bad++;
      $display("FAIL %s status_idle: got %h, want %h", nm, status, exp_status(1'b0));
    end
  endtask

  task automatic quiet_window(input int cycles, input string nm);
    bit seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus_if.bus_req) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL %s no_req: bus_req seen=%b, want 0", nm, seen);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tog = 1'b1;
    ctrl = 13'h1ABC;
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = 8'h00;
    exp_timeout = 0; exp_overrun = 0; exp_last_rnw = 0; exp_rdata = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus_if.bus_req, bus_if.bus_wr, bus_if.bus_addr, bus_if.bus_wdata, status} !== 26'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: req=%b wr=%b addr=%h wdata=%h status=%h, want all 0",
               bus_if.bus_req, bus_if.bus_wr, bus_if.bus_addr, bus_if.bus_wdata, status);
    end
    rst = 1'b0;
    quiet_window(20, "reset_prime");
    n_cmp++;
    if (status !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_status: got %h, want 000", status);
    end
  endtask

  task automatic test_write();
    run_cmd(1'b0, 4'h5, 8'hA3, 8'h00, 2, 1'b0, "write");
  endtask

  task automatic test_read();
    run_cmd(1'b1, 4'hC, 8'h11, 8'h5E, 1, 1'b0, "read");
  endtask

  task automatic test_timeout();
    run_cmd(1'b1, 4'h3, 8'h00, 8'hFF, 0, 1'b0, "timeout");
    run_cmd(1'b0, 4'h9, 8'h42, 8'h00, 1, 1'b0, "after_timeout");
  endtask

  task automatic test_terminal_ack();
    run_cmd(1'b1, 4'h7, 8'h00, 8'hC3, TO, 1'b0, "terminal_ack");
  endtask

  task automatic test_overrun();
    run_cmd(1'b0, 4'hA, 8'h5A, 8'h00, 8, 1'b1, "overrun");
    quiet_window(20, "overrun_drop");
    run_cmd(1'b1, 4'h2, 8'h00, 8'h99, 3, 1'b0, "overrun_sticky");
  endtask

  task automatic test_reset_mid_req();
    int w = 0;
    @(negedge clk);
    ctrl = {1'b1, 4'h6, 8'h00};
    repeat (5) @(negedge clk);
    tog = ~tog;
    while (!bus_if.bus_req && w < 12) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_timeout = 0; exp_overrun = 0; exp_last_rnw = 0; exp_rdata = 8'h00;
    n_cmp++;
    if (bus_if.bus_req !== 1'b0 || status !== 12'h000) begin
      n_bad++;
      $display("FAIL rst_mid_req: req=%b status=%h, want req=0 status=000", bus_if.bus_req, status);
    end
    quiet_window(20, "rst_no_retry");
    n_cmp++;
    if (status !== 12'h000) begin
      n_bad++;
      $display("FAIL rst_mid_idle: status=%h, want 000", status);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      int r;
      int ack_at;
      r = $urandom_range(0, 9);
      if (r <= 5)      ack_at = $urandom_range(1, 4);
      else if (r == 6) ack_at = TO;
      else if (r == 7) ack_at = 0;
      else             ack_at = $urandom_range(5, TO - 1);
      run_cmd(1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), ack_at, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_terminal_ack();
    test_overrun();
    test_random();
    test_reset_mid_req();
    test_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
